// File: rtl/jt12_eg_seq.sv
// Time-multiplexed envelope sequencer: one slot per enabled clock, two-stage pipeline.
// Stage 1 picks the next state and base rate; stage 2 applies the rate step and writes back.
module jt12_eg_seq #(
  parameter int unsigned SLOTS = 24,
  parameter int unsigned EGW   = 10,
  parameter int unsigned SW    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           kon_we,
  input  logic [SW-1:0]  kon_slot,
  input  logic           kon_val,
  input  logic [4:0]     arate,
  input  logic [4:0]     rate1,
  input  logic [4:0]     rate2,
  input  logic [3:0]     rrate,
  input  logic [3:0]     sl,
  input  logic           ssg_en,
  input  logic [2:0]     ssg_eg,
  input  logic           step_en,
  input  logic [1:0]     step_sh,
  output logic [SW-1:0]  slot_s1,
  output logic [4:0]     base_rate,
  output logic [SW-1:0]  slot_s2,
  output logic [2:0]     state_s2,
  output logic [EGW-1:0] eg_out,
  output logic           ssg_inv,
  output logic           pg_rst
);

  typedef enum logic [2:0] {
    StRelease = 3'b000,
    StAttack  = 3'b001,
    StDecay   = 3'b010,
    StHold    = 3'b100
  } eg_state_e;

  localparam logic [SW-1:0]  LastSlot = SW'(SLOTS - 1);
  localparam logic [SW-1:0]  SlotOne  = SW'(1);
  localparam logic [EGW-1:0] LevOne   = EGW'(1);
  localparam logic [EGW:0]   IncOne   = (EGW + 1)'(1);

  // Per-slot storage
  eg_state_e      st_mem    [SLOTS];
  logic [EGW-1:0] lev_mem   [SLOTS];
  logic           inv_mem   [SLOTS];
  logic           latch_mem [SLOTS];
  logic           prev_mem  [SLOTS];

  // Stage-2 pipeline registers not exposed directly
  eg_state_e st_s2;
  logic      inv_s2;

  // Stage-1 view of slot_s1
  eg_state_e      st1;
  logic [EGW-1:0] lev1;
  logic           inv1;
  logic           latch1;
  logic           prev1;
  logic           keyon_now;
  logic           keyoff_now;
  logic [4:0]     sustain;
  logic           above_sus;
  logic           ssg_over;
  logic           ssg_hold;
  eg_state_e      nxt_st;
  logic [4:0]     nxt_rate;
  logic           nxt_inv;
  logic           nxt_pg;

  always_comb begin
    st1        = st_mem[slot_s1];
    lev1       = lev_mem[slot_s1];
    inv1       = inv_mem[slot_s1];
    latch1     = latch_mem[slot_s1];
    prev1      = prev_mem[slot_s1];
    keyon_now  = latch1 & ~prev1;
    keyoff_now = ~latch1 & prev1;
    sustain    = (sl == 4'hf) ? 5'd31 : {1'b0, sl};
    above_sus  = lev1[EGW-1 -: 5] >= sustain;
    ssg_over   = ssg_en & lev1[EGW-1];
    ssg_hold   = ssg_eg[0] & ssg_en;
    nxt_st     = st1;
    nxt_rate   = 5'd0;
    nxt_inv    = inv1;
    nxt_pg     = keyon_now | (ssg_over & ~(ssg_eg[1] | ssg_hold));
    if (keyon_now) begin
      nxt_st   = StAttack;
      nxt_rate = arate;
      nxt_inv  = ssg_eg[2] & ssg_en;
    end else if (keyoff_now || st1 == StRelease) begin
      nxt_st   = StRelease;
      nxt_rate = {rrate, 1'b1};
      nxt_inv  = 1'b0;
    end else begin
      case (st1)
        StAttack: begin
          if (lev1 == '0) begin
            nxt_st   = StDecay;
            nxt_rate = rate1;
          end else begin
            nxt_st   = StAttack;
            nxt_rate = arate;
          end
        end
        StDecay: begin
          if (ssg_over) begin
            // SSG wrap: either freeze or restart the attack, optionally flipping polarity
            nxt_st   = ssg_hold ? StHold : StAttack;
            nxt_rate = ssg_hold ? 5'd0 : arate;
            nxt_inv  = ssg_en & (ssg_eg[1] ^ inv1);
          end else begin
            nxt_st   = StDecay;
            nxt_rate = above_sus ? rate2 : rate1;
          end
        end
        default: begin
          nxt_st   = StHold;
          nxt_rate = 5'd0;
        end
      endcase
    end
  end

  // Stage-2 level arithmetic for slot_s2
  logic [EGW-1:0] lev2;
  logic [2:0]     att_sh;
  logic [EGW-1:0] att_dec;
  logic [EGW:0]   rel_sum;
  logic [EGW-1:0] lev2_nxt;

  always_comb begin
    lev2     = lev_mem[slot_s2];
    att_sh   = 3'd4 - {1'b0, step_sh};
    att_dec  = (lev2 >> att_sh) + LevOne;
    rel_sum  = {1'b0, lev2} + (IncOne << step_sh);
    lev2_nxt = lev2;
    if (step_en && base_rate != 5'd0) begin
      if (st_s2 == StAttack) begin
        lev2_nxt = (att_dec > lev2) ? '0 : lev2 - att_dec;
      end else begin
        lev2_nxt = rel_sum[EGW] ? '1 : rel_sum[EGW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_s1   <= '0;
      slot_s2   <= LastSlot;
      st_s2     <= StRelease;
      base_rate <= 5'd0;
      inv_s2    <= 1'b0;
      pg_rst    <= 1'b0;
      eg_out    <= '1;
      ssg_inv   <= 1'b0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        st_mem[i]    <= StRelease;
        lev_mem[i]   <= '1;
        inv_mem[i]   <= 1'b0;
        latch_mem[i] <= 1'b0;
        prev_mem[i]  <= 1'b0;
      end
    end else begin
      if (cen) begin
        slot_s1           <= (slot_s1 == LastSlot) ? '0 : slot_s1 + SlotOne;
        prev_mem[slot_s1] <= latch1;
        slot_s2           <= slot_s1;
        st_s2             <= nxt_st;
        base_rate         <= nxt_rate;
        inv_s2            <= nxt_inv;
        pg_rst            <= nxt_pg;
        st_mem[slot_s2]   <= st_s2;
        inv_mem[slot_s2]  <= inv_s2;
        lev_mem[slot_s2]  <= lev2_nxt;
        eg_out            <= lev2_nxt;
        ssg_inv           <= inv_s2;
      end
      // Key writes bypass cen; stage 1 reads the old latch value this cycle
      if (kon_we && 32'(kon_slot) < SLOTS) begin
        latch_mem[kon_slot] <= kon_val;
      end
    end
  end

  assign state_s2 = st_s2;

endmodule

// File: doc/jt12_eg_seq.md
Name: jt12_eg_seq

Overview:
Time-multiplexed envelope sequencer for the jt12 operator pipeline, generalising per-slot envelope control to SLOTS slots with EGW-bit attenuation.
- Holds envelope state, level, SSG inversion and key history for every slot.
- Steps one slot per enabled clock through a 2-stage pipeline: stage 1 decides state/base rate, stage 2 applies the rate step returned by the rate counter and writes the slot back.
- Sits between the register file (slot-aligned configuration) and the rate counter / operator attenuation path.

Parameters:
SLOTS, 24, number of operator slots (≥3).
EGW, 10, attenuation width in bits (≥6); all-ones = silence.
SW, 5, slot index width; must satisfy 2^SW ≥ SLOTS.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; all state advances only when high
kon_we  in  1  key write strobe (honoured even when cen=0)
kon_slot  in  SW  slot addressed by kon_we
kon_val  in  1  key value written
arate  in  5  attack rate, aligned to slot_s1
rate1  in  5  decay rate, aligned to slot_s1
rate2  in  5  sustain rate, aligned to slot_s1
rrate  in  4  release rate, aligned to slot_s1
sl  in  4  sustain level, aligned to slot_s1
ssg_en  in  1  SSG enable, aligned to slot_s1
ssg_eg  in  3  SSG mode {att,alt,hold}, aligned to slot_s1
step_en  in  1  rate counter says update, aligned to slot_s2
step_sh  in  2  step magnitude, aligned to slot_s2
slot_s1  out  SW  slot in stage 1
base_rate  out  5  registered base rate of slot_s2
slot_s2  out  SW  slot in stage 2
state_s2  out  3  registered next state of slot_s2
eg_out  out  EGW  written-back level, registered, for slot_s2 of previous cen
ssg_inv  out  1  inversion flag accompanying eg_out
pg_rst  out  1  phase reset for slot_s2

Behaviour:
- Reset (synchronous, rst=1 at clk edge): slot_s1=0; every slot state=RELEASE (3'b000), level=all-ones, inv=0, key latch=0, previous-key=0; base_rate=0, state_s2=0, slot_s2=SLOTS-1, eg_out=all-ones, ssg_inv=0, pg_rst=0. rst overrides cen and kon_we.
- Slot counter: slot_s1 increments on cen, wraps SLOTS-1 → 0. Stage-2 registers take stage-1 results on cen; slot_s2 = previous slot_s1.
- Key: kon_we writes latch[kon_slot]=kon_val. keyon_now = latch & !prev; keyoff_now = !latch & prev, evaluated in stage 1. prev updated to latch at stage-1 on cen. A kon_we aimed at slot_s1 in the same cycle is seen next visit.
- Encoding: ATTACK=001, DECAY=010, HOLD=100, RELEASE=000.
- sustain = (sl==15) ? 31 : {0,sl}; comparison uses top 5 bits of level (lev[EGW-1:EGW-5] ≥ sustain). ssg_over = ssg_en & lev[EGW-1]. ssg_hold = ssg_eg[0] & ssg_en.
- Stage-1 decision, priority order:
  - keyon_now → ATTACK, rate=arate, inv=ssg_eg[2]&ssg_en.
  - keyoff_now or RELEASE → RELEASE, rate={rrate,1}, inv=0.
  - ATTACK: level==0 → DECAY, rate1; else ATTACK, arate.
  - DECAY: ssg_over → HOLD, rate 0 if hold, else ATTACK, arate; inv=ssg_en&(ssg_eg[1]^inv). Otherwise DECAY with rate2 if at/above sustain, else rate1.
  - HOLD: stays HOLD, rate 0.
- pg_rst = keyon_now | (ssg_over & !(ssg_eg[1]|ssg_hold)), registered with stage 2.
- Stage-2 level update (on cen, written to slot_s2 storage and eg_out):
  - No change when step_en=0 or base_rate==0.
  - ATTACK: lev − ((lev >> (4−step_sh)) + 1), clamped at 0.
  - Other states: lev + (1 << step_sh), saturating at all-ones.
  - keyon_now (pg_rst path) does not zero level; attack ramps from current level.
  - SSG ATTACK restart from ssg_over applies in the same way.
- Stage-1 read of a slot never sees a pending stage-2 write for the same slot, because SLOTS ≥ 3 guarantees distance.

Test Plan:
- Reset then 2·SLOTS cycles with cen=1, no keys → eg_out stays 0x3FF, state_s2=000, base_rate cycles {rrate,1}, slot_s1 wraps 23 → 0.
- kon slot 5, arate=31, step_en=1, step_sh=3 → pg_rst=1 on first slot_s2=5, level decreases monotonically to 0, then state_s2=DECAY with base_rate=rate1.
- DECAY, sl=2, rate1=10, rate2=4, step_sh=0 → base_rate switches 10 → 4 when lev[9:5] reaches 2; level +1 per visit, saturates at 0x3FF.
- SSG mode 3'b010 (alt), ssg_en=1 → at lev≥0x200, ATTACK restart, ssg_inv toggles, pg_rst=0. Mode 3'b000 → pg_rst=1. Mode 3'b001 → HOLD, base_rate=0, level frozen.
- kon then koff on slot 7 mid-attack → RELEASE, base_rate={rrate,1}, ssg_inv=0.
- rst asserted mid-attack with cen=0 → all slots RELEASE/0x3FF next edge. kon_we with cen=0 is latched and acted on at the next visit.
